pixel_scheduler: RTL

- Frame controller for the pixel pipeline: walks the SCREEN_WIDTH x SCREEN_HEIGHT raster and issues pixel coordinates to one colour-compute engine over a valid/ready request channel.
- Pairs in-order engine responses with their coordinates in an internal buffer.
- Emits a valid/ready pixel stream with first/last_x/last_y flags to the downstream packer.
- Sits between the host start/stop control and the compute engine / video output.

---
 rtl/pixel_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pixel_scheduler.sv
// pixel_scheduler: raster walker issuing credit-limited engine requests, re-pairing in-order colours with coordinates.
// Optional PIXEL_SCHEDULER_CONTINUOUS_EN: frames repeat back-to-back until stop.
`default_nettype none

module pixel_scheduler #(
    parameter int DATA_WIDTH    = 32,
    parameter int RBG_SIZE      = 24,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [DATA_WIDTH-1:0] req_x,
    output logic [DATA_WIDTH-1:0] req_y,
    input  logic                  resp_valid,
    input  logic [RBG_SIZE-1:0]   resp_colour,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [RBG_SIZE-1:0]   colour_o,
    output logic                  first,
    output logic                  last_x,
    output logic                  last_y
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] X_LAST  = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST  = DATA_WIDTH'(SCREEN_HEIGHT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_ABORT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic [DATA_WIDTH-1:0] x_cnt;
    logic [DATA_WIDTH-1:0] y_cnt;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         col_count;
    logic [PW-1:0]         crd_wr;
    logic [PW-1:0]         crd_rd;
    logic [PW-1:0]         col_wr;
    logic [PW-1:0]         col_rd;

    logic [DATA_WIDTH-1:0] cx_mem  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] cy_mem  [FIFO_DEPTH];
    logic [RBG_SIZE-1:0]   col_mem [FIFO_DEPTH];

    logic issue;
    logic last_issue;
    logic col_nonempty;
    logic resp_take;
    logic pop;

    assign issue        = req_valid && req_ready;
    assign last_issue   = issue && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign col_nonempty = (col_count != '0);
    // Only accept a response that matches a request still awaiting its colour.
    assign resp_take    = resp_valid && (col_count < outstanding);
    // In ABORT the pairs are flushed as soon as their colour lands.
    assign pop          = (state == S_ABORT) ? col_nonempty : (out_valid && out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN: begin
                if (stop)            state_nx = S_ABORT;
                else if (last_issue) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (stop) state_nx = S_ABORT;
                else if ((outstanding == '0) && (col_count == '0)) state_nx = S_DONE;
            end
`ifdef PIXEL_SCHEDULER_CONTINUOUS_EN
            S_DONE:  state_nx = stop ? S_ABORT : S_RUN;
`else
            S_DONE:  state_nx = S_IDLE;
`endif
            S_ABORT: if (outstanding == '0) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        req_valid  = (state == S_RUN) && (outstanding < DEPTH_C);
        out_valid  = ((state == S_RUN) || (state == S_DRAIN)) && col_nonempty;
    end

    always_comb begin
        req_x    = x_cnt;
        req_y    = y_cnt;
        out_x    = out_valid ? cx_mem[crd_rd]  : '0;
        out_y    = out_valid ? cy_mem[crd_rd]  : '0;
        colour_o = out_valid ? col_mem[col_rd] : '0;
        first    = out_valid && (out_x == '0) && (out_y == '0);
        last_x   = out_valid && (out_x == X_LAST);
        last_y   = out_valid && (out_x == X_LAST) && (out_y == Y_LAST);
    end

    // Raster counters only advance in RUN; every other state holds them at the origin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (state != S_RUN) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (issue) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            col_count   <= '0;
            crd_wr      <= '0;
            crd_rd      <= '0;
            col_wr      <= '0;
            col_rd      <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            case ({resp_take, pop})
                2'b10:   col_count <= col_count + 1'b1;
                2'b01:   col_count <= col_count - 1'b1;
                default: col_count <= col_count;
            endcase
            if (issue)     crd_wr <= crd_wr + 1'b1;
            if (pop)       crd_rd <= crd_rd + 1'b1;
            if (resp_take) col_wr <= col_wr + 1'b1;
            if (pop)       col_rd <= col_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            cx_mem[crd_wr] <= x_cnt;
            cy_mem[crd_wr] <= y_cnt;
        end
        if (resp_take) begin
            col_mem[col_wr] <= resp_colour;
        end
    end

endmodule

`default_nettype wire
